adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one registered WIDTH-bit adder (a+b datapath) among NREQ requesters.
- Round-robin arbiter grants one requester at a time, latches its operands, sequences the add and returns a one-cycle done pulse with the result.
- Sits between client FSMs and the shared arithmetic resource; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand and result width in bits.
- NREQ, 4, number of requesters (2..8); index width IDW = $clog2(NREQ).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- req  input  NREQ  per-requester request level; bit i high = requester i wants an add.
- op_a  input  NREQ*WIDTH  packed operand A; slice i = op_a[i*WIDTH +: WIDTH].
- op_b  input  NREQ*WIDTH  packed operand B, same packing.
- grant  output  NREQ  one-hot; requester currently owning the adder.
- done  output  NREQ  one-hot, one-cycle pulse; result valid for that requester.
- result  output  WIDTH  sum of granted operands.
- carry  output  1  carry-out (unsigned overflow) of that sum.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, grant=0, done=0, result=0, carry=0, busy=0, priority pointer ptr=0. In-flight operation is discarded; no done pulse issued afterwards.
- All outputs registered; no combinational path from req/op_* to outputs.
- FSM states: IDLE, EXEC, DONE.
- IDLE: if req!=0, select winner w = first set bit of req searching ptr, ptr+1, ..., wrapping modulo NREQ. At the edge: grant<=onehot(w), latch op_a/op_b slice w into internal regs, state<=EXEC. If req==0, stay IDLE.
- EXEC: at the edge, {carry,result} <= latched_a + latched_b (WIDTH+1-bit sum), done<=onehot(w), state<=DONE. grant stays asserted.
- DONE: done pulse is visible this cycle only. At the edge: done<=0, grant<=0, ptr<=(w+1) mod NREQ, state<=IDLE.
- Latency: request seen in IDLE at cycle 0 -> grant high cycles 1-2 -> done high cycle 2. Max throughput one add per 3 cycles.
- result/carry hold their last value until the next EXEC edge.
- Requester must drop req in the done cycle. A req still high at the following IDLE is treated as a new request.
- Operand changes after the IDLE grant edge have no effect on the in-flight add.
- Requests arriving during EXEC/DONE are ignored until IDLE; no queuing.
- Fairness: a requester holding req continuously is served within NREQ operations.
- ptr wraps from NREQ-1 to 0. With NREQ not a power of two, indices >= NREQ are never granted.
- Simultaneous req bits: only the round-robin winner is granted; grant and done are never multi-hot.

Optional Feature:
- Macro ADDER_SHARE_SAT_EN.
- Defined: result saturates to all-ones when the WIDTH+1 sum overflows; carry still reports overflow.
- Undefined: result wraps modulo 2^WIDTH, with carry equal to bit WIDTH of the sum.

Test Plan:
- Reset, then req=4'b0010, slice1 a=16'h0003 b=16'h0004 -> grant=0010 in cycles 1-2, done=0010 in cycle 2 only, result=16'h0007, carry=0, busy low in cycle 3.
- req=4'b1111 held continuously from reset -> grants in order 0001, 0010, 0100, 1000, 0001, each 3 cycles apart.
- Requester 2, a=16'hFFFF b=16'h0002 -> without macro: result=16'h0001, carry=1. With ADDER_SHARE_SAT_EN: result=16'hFFFF, carry=1.
- Grant requester 0 with a=5 b=6; change slice0 to a=100 during EXEC -> result=11.
- Assert reset during EXEC -> all outputs 0 immediately. No done pulse after release. req=0001 then served with ptr starting at 0.
- ptr=3 after serving requester 2, then req=4'b1001 -> requester 3 granted first, then requester 0.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder among NREQ requesters.
// Define ADDER_SHARE_SAT_EN to saturate the result on unsigned overflow instead of wrapping.
module adder_share_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  carry,
    output logic                  busy
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   win_q, win_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW:0]     cand;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH:0]   sum;

    function automatic logic [NREQ-1:0] to_onehot(input logic [IDW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (idx == IDW'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Search ptr, ptr+1, ... modulo NREQ; the extra bit keeps the wrap exact for any NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!win_found && req[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_a = op_a[i*WIDTH +: WIDTH];
                sel_b = op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        a_d      = a_q;
        b_d      = b_q;
        grant_d  = grant_q;
        done_d   = done_q;
        result_d = result_q;
        carry_d  = carry_q;

        case (state_q)
            StIdle: begin
                if (win_found) begin
                    win_d   = win_idx;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    grant_d = to_onehot(win_idx);
                    state_d = StExec;
                end
            end
            StExec: begin
`ifdef ADDER_SHARE_SAT_EN
                result_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                result_d = sum[WIDTH-1:0];
`endif
                carry_d  = sum[WIDTH];
                done_d   = to_onehot(win_q);
                state_d  = StDone;
            end
            StDone: begin
                done_d  = '0;
                grant_d = '0;
                ptr_d   = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                done_d  = '0;
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            win_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            a_q      <= a_d;
            b_q      <= b_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter with a result scoreboard.
module tb_adder_share_arbiter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREQ  = 4;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  carry;
    logic                  busy;

    typedef struct packed {
        logic [NREQ-1:0]  done;
        logic [WIDTH-1:0] res;
        logic             c;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    adder_share_arbiter #(
        .WIDTH(WIDTH),
        .NREQ (NREQ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .op_a  (op_a),
        .op_b  (op_b),
        .grant (grant),
        .done  (done),
        .result(result),
        .carry (carry),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op_a[i*WIDTH +: WIDTH] = a;
        op_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic push_exp(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH:0] s;
        s      = {1'b0, a} + {1'b0, b};
        e.done = '0;
        e.done[i] = 1'b1;
        e.c    = s[WIDTH];
`ifdef ADDER_SHARE_SAT_EN
        e.res  = s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        e.res  = s[WIDTH-1:0];
`endif
        exp_q.push_back(e);
    endtask

    // Called in the cycle a done pulse is due.
    task automatic check_done(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_done"}, 32'(done), 32'(e.done));
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_carry"}, 32'(carry), 32'(e.c));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] order [5];
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;

        reset = 1'b1;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Single request, latency check.
        set_ops(1, 16'h0003, 16'h0004);
        req = 4'b0010;
        push_exp(1, 16'h0003, 16'h0004);
        tick();
        check("t1_grant_c1", 32'(grant), 32'b0010);
        check("t1_done_c1", 32'(done), 32'd0);
        check("t1_busy_c1", 32'(busy), 32'd1);
        tick();
        check("t1_grant_c2", 32'(grant), 32'b0010);
        check_done("t1");
        req = '0;
        tick();
        check("t1_busy_c3", 32'(busy), 32'd0);
        check("t1_grant_c3", 32'(grant), 32'd0);
        check("t1_done_c3", 32'(done), 32'd0);

        // All requesters held: round-robin order from ptr=0.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, 16'h1000 * 16'(i + 1), 16'(i + 1));
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            push_exp(n % NREQ, 16'h1000 * 16'((n % NREQ) + 1), 16'((n % NREQ) + 1));
            tick();
            check($sformatf("rr_grant_%0d", n), 32'(grant), 32'(order[n]));
            tick();
            check_done($sformatf("rr_%0d", n));
            if (n == 4) req = '0;
            tick();
        end

        // Overflow on requester 2.
        set_ops(2, 16'hFFFF, 16'h0002);
        req = 4'b0100;
        push_exp(2, 16'hFFFF, 16'h0002);
        tick();
        check("ovf_grant", 32'(grant), 32'b0100);
        tick();
        check_done("ovf");
        req = '0;
        tick();

        // ptr now 3: requester 3 wins over 0, then 0.
        set_ops(3, 16'h0010, 16'h0020);
        set_ops(0, 16'h0100, 16'h0200);
        req = 4'b1001;
        push_exp(3, 16'h0010, 16'h0020);
        tick();
        check("ptr_grant_first", 32'(grant), 32'b1000);
        tick();
        check_done("ptr_first");
        tick();
        push_exp(0, 16'h0100, 16'h0200);
        tick();
        check("ptr_grant_second", 32'(grant), 32'b0001);
        tick();
        check_done("ptr_second");
        req = '0;
        tick();

        // Operands changed after the grant edge must not affect the add.
        set_ops(0, 16'd5, 16'd6);
        req = 4'b0001;
        push_exp(0, 16'd5, 16'd6);
        tick();
        set_ops(0, 16'd100, 16'd6);
        check("opchg_grant", 32'(grant), 32'b0001);
        tick();
        check_done("opchg");
        req = '0;
        tick();

        // Reset in EXEC discards the operation and clears ptr.
        set_ops(0, 16'd1, 16'd1);
        req = 4'b0001;
        tick();
        check("mid_busy_pre", 32'(busy), 32'd1);
        req   = '0;
        reset = 1'b1;
        #1;
        check("mid_grant", 32'(grant), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_result", 32'(result), 32'd0);
        check("mid_carry", 32'(carry), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check($sformatf("mid_nodone_%0d", n), 32'(done), 32'd0);
        end
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, 16'(i + 7), 16'h0001);
        end
        req = 4'b1111;
        push_exp(0, 16'd7, 16'h0001);
        tick();
        check("post_grant", 32'(grant), 32'b0001);
        tick();
        check_done("post");
        req = '0;
        tick();
        check("post_busy", 32'(busy), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
